bp_sample_sequencer: RTL and testbench
======================================

Name: bp_sample_sequencer

Overview:
Upstream feeder for the back-propagation network core. It stores up to DEPTH training samples, each holding four signed inputs and two signed desired outputs. On start it presents the samples in order for a programmable number of epochs. Each sample is held stable for exactly HOLD_CYCLES clocks so the core can run forward pass, error and weight update, with no gap between samples.

Parameters:
- DATA_W, 9: width of each signed field (x0..x3, desired_y0/1).
- DEPTH, 200: sample storage entries.
- ADDR_W, 8: index width; ceil(log2(DEPTH)).
- HOLD_CYCLES, 24: clocks each sample is presented; must be ≥2.
- EPOCH_W, 8: epoch counter width.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- load_en  in  1  write one sample into storage (ignored while busy).
- load_addr  in  ADDR_W  write index.
- load_data  in  6*DATA_W  packed {x0,x1,x2,x3,desired_y0,desired_y1}, x0 in MSBs.
- num_samples  in  ADDR_W+1  samples per epoch; latched on accepted start.
- num_epochs  in  EPOCH_W  epoch count; latched on accepted start.
- start  in  1  begin a run (level sampled, accepted only in IDLE).
- abort  in  1  terminate the run.
- x0,x1,x2,x3  out  DATA_W signed each  current inputs to the core.
- desired_y0,desired_y1  out  DATA_W signed each  current targets.
- sample_valid  out  1  outputs are a live sample.
- sample_strobe  out  1  one-cycle pulse on the first cycle of each new sample.
- sample_idx  out  ADDR_W  index currently presented.
- epoch_idx  out  EPOCH_W  current epoch, 0-based.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (RST=0, async): FSM to IDLE; all outputs 0; counters 0. Storage contents are not reset.
- States:
  - IDLE → PRIME on start, when num_samples≠0, num_epochs≠0 and num_samples≤DEPTH.
  - If start arrives with any count 0 or num_samples>DEPTH: stay IDLE and pulse done the next cycle.
  - PRIME (1 cycle): sync read of address 0; busy=1.
  - PRESENT: output registers load the read data; hold counter counts 0..HOLD_CYCLES-1.
- Latency: start accepted at edge k; PRIME during cycle k+1; first sample visible with sample_valid=1 and sample_strobe=1 at edge k+2.
- Prefetch: when hold counter = HOLD_CYCLES-2, read the next index. Next index is idx+1, or 0 when idx=num_samples-1. The next sample appears exactly HOLD_CYCLES cycles after the previous strobe, so sample_valid stays high across sample boundaries.
- Wrap-around: after the last sample, epoch_idx increments.
- Completion: after the last sample of epoch num_epochs-1 finishes its hold, go to IDLE. That cycle: sample_valid=0, busy=0, done=1. Data outputs keep their last values.
- abort (any non-IDLE state): next edge goes to IDLE; sample_valid, busy and strobe drop; no done pulse. abort in IDLE has no effect. abort has priority over completion in the same cycle.
- start while busy: ignored. num_samples and num_epochs changes after start: ignored.
- load_en while busy: write dropped. load_en and start in the same IDLE cycle: the write is performed and the run starts, with the new data visible if it is at address 0.
- Signed fields pass through bit-exact; no arithmetic on data.
- Total valid cycles per run = num_samples*num_epochs*HOLD_CYCLES.

Decomposition:
- Package bp_nn_pkg holds:
  - DATA_W and the field slice offsets for the packed sample.
  - The sequencer state enum {IDLE, PRIME, PRESENT}.
  - A helper constant SAMPLE_W = 6*DATA_W.
  - The same package is shared with the network core.
- Sub-module bp_sample_ram: DEPTH×SAMPLE_W, one write port, one synchronous read port, no reset.

Test Plan:
- Load 3 samples (idx0 x0=1…dy1=6, idx1 = 7…12, idx2 = -256,255,0,-1,100,-100). num_samples=3, num_epochs=2, HOLD_CYCLES=4, start:
  - sample_valid high for 24 contiguous cycles.
  - Index order 0,1,2,0,1,2; 6 strobes spaced exactly 4 apart.
  - epoch_idx goes 0→1 at the 4th strobe.
  - done pulses exactly once, in the cycle after the last valid cycle.
- start with num_samples=0 → no sample_valid; done=1 the next cycle; busy stays 0.
- Assert abort in the 2nd cycle of sample 1 → IDLE next cycle; sample_valid=0; done never asserts. A following start replays from idx0, epoch 0.
- Drive RST low mid-run for 1 cycle (asynchronous, off-edge) → outputs 0 immediately. After release, IDLE; storage intact, and the next start presents the original idx0 values.
- load_en to idx1 with new data while busy → idx1 unchanged on presentation. The same write in IDLE → new values presented.
- start re-asserted during a run, and counts changed mid-run → run length and order unaffected (24 valid cycles as in the first scenario).

Source files
------------

// File: rtl/bp_nn_pkg.sv
// Shared definitions for the back-propagation network datapath.
// Holds the data width, the packed-sample layout
// {x0,x1,x2,x3,desired_y0,desired_y1} with x0 in the MSBs, and the
// sample sequencer state encoding. The network core imports this too.
package bp_nn_pkg;

  localparam int DATA_W   = 9;
  localparam int SAMPLE_W = 6 * DATA_W;

  // Field numbers inside a packed sample, MSB field first.
  localparam int FLD_X0  = 0;
  localparam int FLD_X1  = 1;
  localparam int FLD_X2  = 2;
  localparam int FLD_X3  = 3;
  localparam int FLD_DY0 = 4;
  localparam int FLD_DY1 = 5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRIME   = 2'd1,
    S_PRESENT = 2'd2
  } seq_state_e;

  // LSB position of field 'fld' in a packed sample of w-bit fields.
  function automatic int fld_lsb(input int fld, input int w);
    return (5 - fld) * w;
  endfunction

endpackage

// File: rtl/bp_sample_ram.sv
// Training-sample storage: DEPTH x W, one write port, one registered
// read port. No reset on the array or the read register.
// Ports:
//   i_clk            clock
//   i_we/i_waddr/i_wdata  write one entry (addresses >= DEPTH dropped)
//   i_re/i_raddr     read request; o_rdata valid the cycle after
module bp_sample_ram #(
  parameter int DEPTH  = 200,
  parameter int ADDR_W = 8,
  parameter int W      = bp_nn_pkg::SAMPLE_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [W-1:0]      i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [W-1:0]      o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we && (32'(i_waddr) < DEPTH)) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/bp_sample_sequencer.sv
// Feeds stored training samples to the back-propagation core. Each
// sample is held for HOLD_CYCLES clocks, samples run back to back for
// num_epochs passes over num_samples entries.
// Ports:
//   CLK, RST (async, active low)
//   load_en/load_addr/load_data  sample write (IDLE only)
//   num_samples/num_epochs/start  run setup, latched when start accepted
//   abort                         stop a run without a done pulse
//   x0..x3, desired_y0/1          current sample fields
//   sample_valid/sample_strobe    live sample / first cycle of a sample
//   sample_idx/epoch_idx          current position in the run
//   busy, done                    run active / one-cycle completion
module bp_sample_sequencer #(
  parameter int DATA_W      = bp_nn_pkg::DATA_W,
  parameter int DEPTH       = 200,
  parameter int ADDR_W      = 8,
  parameter int HOLD_CYCLES = 24,
  parameter int EPOCH_W     = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     load_en,
  input  logic [ADDR_W-1:0]        load_addr,
  input  logic [6*DATA_W-1:0]      load_data,
  input  logic [ADDR_W:0]          num_samples,
  input  logic [EPOCH_W-1:0]       num_epochs,
  input  logic                     start,
  input  logic                     abort,
  output logic signed [DATA_W-1:0] x0,
  output logic signed [DATA_W-1:0] x1,
  output logic signed [DATA_W-1:0] x2,
  output logic signed [DATA_W-1:0] x3,
  output logic signed [DATA_W-1:0] desired_y0,
  output logic signed [DATA_W-1:0] desired_y1,
  output logic                     sample_valid,
  output logic                     sample_strobe,
  output logic [ADDR_W-1:0]        sample_idx,
  output logic [EPOCH_W-1:0]       epoch_idx,
  output logic                     busy,
  output logic                     done
);
  import bp_nn_pkg::*;

  localparam int SMP_W  = 6 * DATA_W;
  localparam int HOLD_W = $clog2(HOLD_CYCLES);

  seq_state_e          r_state;
  logic [SMP_W-1:0]    r_data;
  logic                r_valid, r_strobe, r_done;
  logic [HOLD_W-1:0]   r_hold;
  logic [ADDR_W-1:0]   r_idx;
  logic [EPOCH_W-1:0]  r_epoch;
  logic [ADDR_W:0]     r_ns;
  logic [EPOCH_W-1:0]  r_ne;

  logic                w_cnt_ok, w_hold_end, w_last_smp, w_last_ep;
  logic                w_we, w_rd_en;
  logic [ADDR_W-1:0]   w_next_idx, w_rd_addr;
  logic [SMP_W-1:0]    w_rd_data;

  assign w_cnt_ok   = (num_samples != '0) && (num_epochs != '0) &&
                      (num_samples <= (ADDR_W+1)'(DEPTH));
  assign w_hold_end = (r_hold == HOLD_W'(HOLD_CYCLES - 1));
  assign w_last_smp = ({1'b0, r_idx} == r_ns - (ADDR_W+1)'(1));
  assign w_last_ep  = (r_epoch == r_ne - EPOCH_W'(1));
  assign w_next_idx = w_last_smp ? '0 : r_idx + ADDR_W'(1);

  // Read-to-display is two edges (RAM register, then output register),
  // so the next entry is fetched two cycles before the boundary. PRIME
  // fetches entry 0 the same way.
  assign w_rd_en   = (r_state == S_PRIME) ||
                     ((r_state == S_PRESENT) && (r_hold == HOLD_W'(HOLD_CYCLES - 2)));
  assign w_rd_addr = (r_state == S_PRESENT) ? w_next_idx : '0;
  assign w_we      = load_en && (r_state == S_IDLE);

  bp_sample_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(SMP_W)) u_ram (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      r_hold   <= '0;
      r_idx    <= '0;
      r_epoch  <= '0;
      r_ns     <= '0;
      r_ne     <= '0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      unique case (r_state)
        S_IDLE: if (start) begin
          if (w_cnt_ok) begin
            r_state <= S_PRIME;
            r_ns    <= num_samples;
            r_ne    <= num_epochs;
            r_idx   <= '0;
            r_epoch <= '0;
          end else begin
            r_done  <= 1'b1;
          end
        end
        S_PRIME: begin
          // Enter PRESENT one cycle short of a boundary with nothing
          // shown, so the first sample loads through the normal path.
          r_state <= abort ? S_IDLE : S_PRESENT;
          r_hold  <= HOLD_W'(HOLD_CYCLES - 1);
        end
        S_PRESENT: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end else if (!w_hold_end) begin
            r_hold  <= r_hold + HOLD_W'(1);
          end else if (!r_valid) begin
            r_data   <= w_rd_data;
            r_valid  <= 1'b1;
            r_strobe <= 1'b1;
            r_hold   <= '0;
          end else if (w_last_smp && w_last_ep) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_data   <= w_rd_data;
            r_strobe <= 1'b1;
            r_hold   <= '0;
            r_idx    <= w_next_idx;
            if (w_last_smp) r_epoch <= r_epoch + EPOCH_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign x0            = r_data[fld_lsb(FLD_X0,  DATA_W) +: DATA_W];
  assign x1            = r_data[fld_lsb(FLD_X1,  DATA_W) +: DATA_W];
  assign x2            = r_data[fld_lsb(FLD_X2,  DATA_W) +: DATA_W];
  assign x3            = r_data[fld_lsb(FLD_X3,  DATA_W) +: DATA_W];
  assign desired_y0    = r_data[fld_lsb(FLD_DY0, DATA_W) +: DATA_W];
  assign desired_y1    = r_data[fld_lsb(FLD_DY1, DATA_W) +: DATA_W];
  assign sample_valid  = r_valid;
  assign sample_strobe = r_strobe;
  assign sample_idx    = r_idx;
  assign epoch_idx     = r_epoch;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;

endmodule

// File: tb/tb_bp_sample_sequencer.sv
module tb_bp_sample_sequencer;
  localparam int DW = 9, DEPTH = 200, AW = 8, HOLD = 4, EW = 8, SW = 6 * DW;

  logic CLK = 1'b0, RST = 1'b0;
  logic load_en = 1'b0, start = 1'b0, abort = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [SW-1:0] load_data = '0;
  logic [AW:0]   num_samples = '0;
  logic [EW-1:0] num_epochs = '0;
  logic signed [DW-1:0] x0, x1, x2, x3, desired_y0, desired_y1;
  logic sample_valid, sample_strobe, busy, done;
  logic [AW-1:0] sample_idx;
  logic [EW-1:0] epoch_idx;

  bp_sample_sequencer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW),
                        .HOLD_CYCLES(HOLD), .EPOCH_W(EW)) dut (
    .CLK(CLK), .RST(RST), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_samples(num_samples), .num_epochs(num_epochs),
    .start(start), .abort(abort), .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .desired_y0(desired_y0), .desired_y1(desired_y1),
    .sample_valid(sample_valid), .sample_strobe(sample_strobe),
    .sample_idx(sample_idx), .epoch_idx(epoch_idx), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [EW-1:0] ep;
    logic [SW-1:0] data;
  } exp_t;

  exp_t sb[$];
  logic [SW-1:0] model [DEPTH];
  int checks = 0, errors = 0;
  int w_valid, w_rise, w_done, w_done_ok, w_done_c, w_first, w_busy, w_extra;

  function automatic logic [SW-1:0] pk(input int a, input int b, input int c,
                                       input int d, input int e, input int f);
    return {a[DW-1:0], b[DW-1:0], c[DW-1:0], d[DW-1:0], e[DW-1:0], f[DW-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input logic [SW-1:0] d);
    @(negedge CLK); load_en = 1'b1; load_addr = AW'(addr); load_data = d;
    @(negedge CLK); load_en = 1'b0;
  endtask

  task automatic push_run(input int ns, input int ne);
    for (int e = 0; e < ne; e++)
      for (int i = 0; i < ns; i++)
        sb.push_back('{idx: AW'(i), ep: EW'(e), data: model[i]});
  endtask

  // start presented for exactly one rising edge, optionally with a write
  task automatic go(input int ns, input int ne, input bit wr, input int addr,
                    input logic [SW-1:0] d);
    @(negedge CLK);
    num_samples = (AW+1)'(ns); num_epochs = EW'(ne); start = 1'b1;
    load_en = wr; load_addr = AW'(addr); load_data = d;
    @(posedge CLK); #1 start = 1'b0; load_en = 1'b0;
  endtask

  // Observe ncyc cycles from the cycle after start acceptance; c==0 is
  // that first cycle. Strobes pop the scoreboard and compare.
  task automatic watch(input int ncyc, input int abort_at, input int restart_at,
                       input int wr_at);
    exp_t e; logic pv; int last_s;
    w_valid = 0; w_rise = 0; w_done = 0; w_done_ok = 0; w_done_c = -1;
    w_first = -1; w_busy = 0; w_extra = 0; pv = 1'b0; last_s = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      if (sample_valid) begin w_valid++; if (!pv) w_rise++; end
      if (busy) w_busy++;
      if (done) begin
        w_done++; w_done_c = c;
        if (pv && !sample_valid && !busy) w_done_ok++;
      end
      if (sample_strobe) begin
        if (w_first < 0) w_first = c;
        if (sb.size() == 0) w_extra++;
        else begin
          e = sb.pop_front();
          chk("idx", 64'(sample_idx), 64'(e.idx));
          chk("epoch", 64'(epoch_idx), 64'(e.ep));
          chk("data", 64'({x0, x1, x2, x3, desired_y0, desired_y1}), 64'(e.data));
          if (last_s >= 0) chk("spacing", 64'(c - last_s), 64'(HOLD));
        end
        last_s = c;
      end
      pv = sample_valid;
      abort = (c == abort_at);
      start = (c == restart_at);
      if (c == restart_at) begin num_samples = 1; num_epochs = 5; end
      load_en = (c == wr_at); load_addr = 1; load_data = pk(-1, -2, -3, -4, -5, -6);
    end
    abort = 1'b0; start = 1'b0; load_en = 1'b0;
  endtask

  task automatic chk_full_run(input string tag);
    chk({tag, "_valid"}, 64'(w_valid), 64'(3 * 2 * HOLD));
    chk({tag, "_contig"}, 64'(w_rise), 64'(1));
    chk({tag, "_first"}, 64'(w_first), 64'(2));
    chk({tag, "_busy"}, 64'(w_busy), 64'(2 + 3 * 2 * HOLD));
    chk({tag, "_done_cnt"}, 64'(w_done), 64'(1));
    chk({tag, "_done_pos"}, 64'(w_done_ok), 64'(1));
    chk({tag, "_extra"}, 64'(w_extra), 64'(0));
    chk({tag, "_sb_left"}, 64'(sb.size()), 64'(0));
  endtask

  task automatic chk_rejected(input string tag);
    watch(5, -1, -1, -1);
    chk({tag, "_valid"}, 64'(w_valid), 64'(0));
    chk({tag, "_done"}, 64'(w_done), 64'(1));
    chk({tag, "_done_c"}, 64'(w_done_c), 64'(0));
    chk({tag, "_busy"}, 64'(w_busy), 64'(0));
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge CLK);
    chk("rst_valid", 64'(sample_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_strobe", 64'(sample_strobe), 64'(0));
    chk("rst_pos", 64'({sample_idx, epoch_idx}), 64'(0));
    chk("rst_data", 64'({x0, x1, x2, x3, desired_y0, desired_y1}), 64'(0));
    #2 RST = 1'b1;

    // three samples, 3 x 2 run
    model[0] = pk(1, 2, 3, 4, 5, 6);
    model[1] = pk(7, 8, 9, 10, 11, 12);
    model[2] = pk(-256, 255, 0, -1, 100, -100);
    for (int i = 0; i < 3; i++) load(i, model[i]);
    push_run(3, 2);
    go(3, 2, 1'b0, 0, '0);
    watch(32, -1, -1, -1);
    chk_full_run("main");

    // rejected starts
    go(0, 2, 1'b0, 0, '0);   chk_rejected("ns0");
    go(3, 0, 1'b0, 0, '0);   chk_rejected("ne0");
    go(201, 1, 1'b0, 0, '0); chk_rejected("ns_over");

    // abort in second cycle of sample 1, then a clean replay
    push_run(2, 1);
    go(3, 2, 1'b0, 0, '0);
    watch(12, 7, -1, -1);
    chk("abort_valid", 64'(w_valid), 64'(6));
    chk("abort_busy", 64'(w_busy), 64'(8));
    chk("abort_done", 64'(w_done), 64'(0));
    chk("abort_sb", 64'(sb.size()), 64'(0));
    push_run(3, 2);
    go(3, 2, 1'b0, 0, '0);
    watch(32, -1, -1, -1);
    chk_full_run("replay");

    // start re-asserted with different counts mid-run
    push_run(3, 2);
    go(3, 2, 1'b0, 0, '0);
    watch(32, -1, 10, -1);
    chk_full_run("restart");
    num_samples = 3; num_epochs = 2;

    // asynchronous reset mid-run
    push_run(3, 2);
    go(3, 2, 1'b0, 0, '0);
    watch(10, -1, -1, -1);
    sb.delete();
    #2 RST = 1'b0;
    #1;
    chk("arst_valid", 64'(sample_valid), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_data", 64'({x0, x1, x2, x3, desired_y0, desired_y1}), 64'(0));
    chk("arst_pos", 64'({sample_idx, epoch_idx}), 64'(0));
    #10 RST = 1'b1;
    @(negedge CLK);
    chk("arst_idle", 64'(busy), 64'(0));
    push_run(3, 2);
    go(3, 2, 1'b0, 0, '0);
    watch(32, -1, -1, -1);
    chk_full_run("post_rst");

    // write while busy is dropped
    push_run(3, 1);
    go(3, 1, 1'b0, 0, '0);
    watch(20, -1, -1, 3);
    chk("busywr_sb", 64'(sb.size()), 64'(0));
    chk("busywr_done", 64'(w_done), 64'(1));

    // write in IDLE takes effect
    model[1] = pk(50, -50, 25, -25, 12, -12);
    load(1, model[1]);
    push_run(3, 1);
    go(3, 1, 1'b0, 0, '0);
    watch(20, -1, -1, -1);
    chk("idlewr_sb", 64'(sb.size()), 64'(0));

    // write to entry 0 in the same cycle as start
    model[0] = pk(-7, 8, -9, 10, -11, 12);
    push_run(3, 1);
    go(3, 1, 1'b1, 0, model[0]);
    watch(20, -1, -1, -1);
    chk("samecyc_sb", 64'(sb.size()), 64'(0));
    chk("samecyc_valid", 64'(w_valid), 64'(3 * HOLD));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
